// File: rtl/addsub_shared_scheduler_if.sv
// Requester/result bundle for addsub_shared_scheduler: N requesters in, one result stream out.
interface addsub_shared_scheduler_if #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned REQ_COUNT  = 4
);
  localparam int unsigned ID_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  logic [REQ_COUNT-1:0]            req_valid;
  logic [REQ_COUNT-1:0]            req_ready;
  logic [REQ_COUNT*WORD_WIDTH-1:0] req_A;
  logic [REQ_COUNT-1:0]            req_A_negative;
  logic [REQ_COUNT*WORD_WIDTH-1:0] req_B;
  logic [REQ_COUNT-1:0]            req_B_negative;

  logic                            res_valid;
  logic                            res_ready;
  logic [ID_WIDTH-1:0]             res_id;
  logic [WORD_WIDTH-1:0]           res_sum;
  logic                            res_carry_out;
  logic                            res_overflow;

  // Requesters and result consumer side
  modport master (
    output req_valid, req_A, req_A_negative, req_B, req_B_negative, res_ready,
    input  req_ready, res_valid, res_id, res_sum, res_carry_out, res_overflow
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_A, req_A_negative, req_B, req_B_negative, res_ready,
    output req_ready, res_valid, res_id, res_sum, res_carry_out, res_overflow
  );
endinterface

// File: rtl/addsub_shared_scheduler.sv
// Round-robin scheduler sharing one adder/subtractor among REQ_COUNT requesters
// through a two-stage (operand, result) valid/ready pipeline.
module addsub_shared_scheduler #(
  parameter int unsigned WORD_WIDTH = 36,
  parameter int unsigned REQ_COUNT  = 4
) (
  input  logic                          i_clock,
  input  logic                          i_clear,
  addsub_shared_scheduler_if.slave      bus,
  output logic                          o_idle
);
  localparam int unsigned ID_WIDTH  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int unsigned SUM_WIDTH = WORD_WIDTH + 1;

  // Round-robin pointer
  logic [ID_WIDTH-1:0]   r_ptr;

  // Operand stage
  logic                  r_s1_valid;
  logic [WORD_WIDTH-1:0] r_s1_a;
  logic                  r_s1_a_neg;
  logic [WORD_WIDTH-1:0] r_s1_b;
  logic                  r_s1_b_neg;
  logic [ID_WIDTH-1:0]   r_s1_id;

  // Result stage
  logic                  r_s2_valid;
  logic [WORD_WIDTH-1:0] r_s2_sum;
  logic                  r_s2_carry;
  logic                  r_s2_ovf;
  logic [ID_WIDTH-1:0]   r_s2_id;

  logic [REQ_COUNT-1:0]  w_grant;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic                  w_found;
  int unsigned           w_idx;
  logic [WORD_WIDTH-1:0] w_sel_a;
  logic [WORD_WIDTH-1:0] w_sel_b;
  logic                  w_sel_a_neg;
  logic                  w_sel_b_neg;
  logic                  w_res_hs;
  logic                  w_s2_load;
  logic                  w_s1_can_load;
  logic                  w_req_hs;
  logic [WORD_WIDTH-1:0] w_x;
  logic [WORD_WIDTH-1:0] w_y;
  logic [SUM_WIDTH-1:0]  w_sum_full;
  logic                  w_cin_msb;
  logic                  w_ovf;

  // Round-robin search starting at the pointer, wrapping modulo REQ_COUNT
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      w_idx = (32'(r_ptr) + k) % REQ_COUNT;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_id     = ID_WIDTH'(w_idx);
      end
    end
  end

  // Operand mux driven by the one-hot grant
  always_comb begin
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_sel_a_neg = 1'b0;
    w_sel_b_neg = 1'b0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (w_grant[i]) begin
        w_sel_a     = bus.req_A[i*WORD_WIDTH +: WORD_WIDTH];
        w_sel_b     = bus.req_B[i*WORD_WIDTH +: WORD_WIDTH];
        w_sel_a_neg = bus.req_A_negative[i];
        w_sel_b_neg = bus.req_B_negative[i];
      end
    end
  end

  // Pipeline advance conditions; stage 1 may refill in the same cycle it drains
  assign w_res_hs      = bus.res_valid & bus.res_ready;
  assign w_s2_load     = r_s1_valid & (~r_s2_valid | w_res_hs);
  assign w_s1_can_load = ~r_s1_valid | w_s2_load;
  assign w_req_hs      = w_found & w_s1_can_load & ~i_clear;
  assign bus.req_ready = w_grant & {REQ_COUNT{w_s1_can_load & ~i_clear}};

  // Shared adder: negation as one's complement plus carry-in
  always_comb begin
    w_x        = r_s1_a_neg ? ~r_s1_a : r_s1_a;
    w_y        = r_s1_b_neg ? ~r_s1_b : r_s1_b;
    w_sum_full = {1'b0, w_x} + {1'b0, w_y}
               + SUM_WIDTH'(r_s1_a_neg) + SUM_WIDTH'(r_s1_b_neg);
    w_cin_msb  = w_x[WORD_WIDTH-1] ^ w_y[WORD_WIDTH-1] ^ w_sum_full[WORD_WIDTH-1];
    w_ovf      = w_cin_msb ^ w_sum_full[WORD_WIDTH];
  end

  // Pointer moves past the winner only on an accepted request
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_ptr <= '0;
    end else if (w_req_hs) begin
      r_ptr <= (w_grant_id == ID_WIDTH'(REQ_COUNT - 1)) ? '0 : w_grant_id + ID_WIDTH'(1);
    end
  end

  // Operand stage register
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_a_neg <= 1'b0;
      r_s1_b     <= '0;
      r_s1_b_neg <= 1'b0;
      r_s1_id    <= '0;
    end else if (w_req_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= w_sel_a;
      r_s1_a_neg <= w_sel_a_neg;
      r_s1_b     <= w_sel_b;
      r_s1_b_neg <= w_sel_b_neg;
      r_s1_id    <= w_grant_id;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Result stage register; holds stable under backpressure
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_carry <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_id    <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s2_sum   <= w_sum_full[WORD_WIDTH-1:0];
      r_s2_carry <= w_sum_full[WORD_WIDTH];
      r_s2_ovf   <= w_ovf;
      r_s2_id    <= r_s1_id;
    end else if (w_res_hs) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.res_valid     = r_s2_valid & ~i_clear;
  assign bus.res_id        = r_s2_id;
  assign bus.res_sum       = r_s2_sum;
  assign bus.res_carry_out = r_s2_carry;
  assign bus.res_overflow  = r_s2_ovf;

  // While clear is high the stages are treated as empty
  assign o_idle = ~(|bus.req_valid) & (i_clear | (~r_s1_valid & ~r_s2_valid));

endmodule
